// File: rtl/tensor_addr_gen_pkg.sv
// Shared constants, descriptor layout and state type for the tensor
// address generators.
package tensor_addr_gen_pkg;

    localparam int BCNT = 24;
    localparam int BSTR = 5;
    localparam int BTCR = BCNT + 3 * BCNT + 3 * BSTR;

    localparam int BASE_OFF  = 0;
    localparam int SIZE0_OFF = 24;
    localparam int SIZE1_OFF = 48;
    localparam int SIZE2_OFF = 72;
    localparam int STR0_OFF  = 96;
    localparam int STR1_OFF  = 101;
    localparam int STR2_OFF  = 106;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Full-width sum; the caller truncates to the bank address width.
    function automatic logic [BCNT-1:0] calc_addr(
        input logic [BCNT-1:0] base,
        input logic [BCNT-1:0] i0,
        input logic [BCNT-1:0] i1,
        input logic [BCNT-1:0] i2,
        input logic [BSTR-1:0] s0,
        input logic [BSTR-1:0] s1,
        input logic [BSTR-1:0] s2
    );
        return base + (i0 << s0) + (i1 << s1) + (i2 << s2);
    endfunction

endpackage

// File: rtl/tensor_addr_gen_loop_cnt.sv
// Three-level nested wrap counter; i0 is the innermost loop.
// Exposes the post-advance values so callers can precompute ahead.
module tensor_loop_cnt
    import tensor_addr_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            adv,
    input  logic [BCNT-1:0] size0,
    input  logic [BCNT-1:0] size1,
    input  logic [BCNT-1:0] size2,
    output logic [BCNT-1:0] i0,
    output logic [BCNT-1:0] i1,
    output logic [BCNT-1:0] i2,
    output logic [BCNT-1:0] n0,
    output logic [BCNT-1:0] n1,
    output logic [BCNT-1:0] n2,
    output logic            wrap0,
    output logic            wrap1,
    output logic            all_max
);

    logic at0;
    logic at1;
    logic at2;

    assign at0     = (i0 == size0);
    assign at1     = (i1 == size1);
    assign at2     = (i2 == size2);
    assign wrap0   = at0;
    assign wrap1   = at0 && at1;
    assign all_max = at0 && at1 && at2;

    always_comb begin
        n0 = at0 ? '0 : i0 + 1'b1;
        n1 = i1;
        n2 = i2;
        if (wrap0) begin
            n1 = at1 ? '0 : i1 + 1'b1;
        end
        if (wrap1) begin
            n2 = at2 ? '0 : i2 + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i0 <= '0;
            i1 <= '0;
            i2 <= '0;
        end else if (clr) begin
            i0 <= '0;
            i1 <= '0;
            i2 <= '0;
        end else if (adv) begin
            i0 <= n0;
            i1 <= n1;
            i2 <= n2;
        end
    end

endmodule

// File: rtl/tensor_addr_gen.sv
// Walks a 3-D tensor descriptor, presenting one registered bank
// address per granted request.
module tensor_addr_gen
    import tensor_addr_gen_pkg::*;
#(
    parameter int BADDR = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [BTCR-1:0]  cfg_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             addr_en,
    input  logic             addr_grnt,
    output logic [BADDR-1:0] addr,
    output logic             addr_last
);

    state_t          state;
    logic [BTCR-1:0] desc;
    logic [BTCR-1:0] src;

    logic [BCNT-1:0] base;
    logic [BCNT-1:0] sz0;
    logic [BCNT-1:0] sz1;
    logic [BCNT-1:0] sz2;
    logic [BSTR-1:0] st0;
    logic [BSTR-1:0] st1;
    logic [BSTR-1:0] st2;

    logic [BCNT-1:0] i0;
    logic [BCNT-1:0] i1;
    logic [BCNT-1:0] i2;
    logic [BCNT-1:0] n0;
    logic [BCNT-1:0] n1;
    logic [BCNT-1:0] n2;
    logic            wrap0;
    logic            wrap1;
    logic            all_max;

    logic            xfer;
    logic            go;
    logic [BCNT-1:0] nxt_a;
    logic            nxt_last;
    logic [BCNT-1:0] src_base;
    logic            src_last;

    assign base = desc[BASE_OFF  +: BCNT];
    assign sz0  = desc[SIZE0_OFF +: BCNT];
    assign sz1  = desc[SIZE1_OFF +: BCNT];
    assign sz2  = desc[SIZE2_OFF +: BCNT];
    assign st0  = desc[STR0_OFF  +: BSTR];
    assign st1  = desc[STR1_OFF  +: BSTR];
    assign st2  = desc[STR2_OFF  +: BSTR];

    // A load in the start cycle must already steer the first address.
    assign src      = (state == IDLE && cfg_we) ? cfg_data : desc;
    assign src_base = src[BASE_OFF +: BCNT];
    assign src_last = (src[SIZE0_OFF +: BCNT] == '0)
                   && (src[SIZE1_OFF +: BCNT] == '0)
                   && (src[SIZE2_OFF +: BCNT] == '0);

    assign xfer     = addr_en && addr_grnt;
    assign go       = (state == IDLE) && start;
    assign nxt_a    = calc_addr(base, n0, n1, n2, st0, st1, st2);
    assign nxt_last = (n0 == sz0) && (n1 == sz1) && (n2 == sz2);

    tensor_loop_cnt u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (go),
        .adv     (xfer),
        .size0   (sz0),
        .size1   (sz1),
        .size2   (sz2),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .n0      (n0),
        .n1      (n1),
        .n2      (n2),
        .wrap0   (wrap0),
        .wrap1   (wrap1),
        .all_max (all_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            desc      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_en   <= 1'b0;
            addr      <= '0;
            addr_last <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_we) begin
                        desc <= cfg_data;
                    end
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        addr_en   <= 1'b1;
                        addr      <= src_base[BADDR-1:0];
                        addr_last <= src_last;
                    end
                end
                RUN: begin
                    if (xfer && addr_last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        addr_en   <= 1'b0;
                        addr_last <= 1'b0;
                        done      <= 1'b1;
                    end else if (xfer) begin
                        addr      <= nxt_a[BADDR-1:0];
                        addr_last <= nxt_last;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
